// File: rtl/dmgplus_pkg.sv
// Shared definitions for the DMG+ cartridge ROM arbiter slice.
package dmgplus_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // Requester indices
  localparam int unsigned REQ_SPLASH = 0;
  localparam int unsigned REQ_CPU    = 1;

  // Upper bound on requesters; owner/last_owner are 2 bits wide
  localparam int unsigned DMGPLUS_MAX_REQ = 4;

endpackage : dmgplus_pkg

// File: rtl/dmgplus_rom_arb_pick.sv
// Combinational winner select for the ROM arbiter.
// ROM_ARB_RR_EN undefined: fixed priority, lowest pending index wins.
// ROM_ARB_RR_EN defined:   round robin, search starts at (last_owner_i + 1) mod NREQ.
module dmgplus_rom_arb_pick
  import dmgplus_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [1:0]      last_owner_i,
  output logic            valid_o,
  output logic [1:0]      winner_o
);

  localparam int N = int'(NREQ);

`ifdef ROM_ARB_RR_EN

  // Walk offsets from farthest to nearest so the slot right after last_owner overrides the rest
  always_comb begin
    int slot;
    valid_o  = 1'b0;
    winner_o = 2'd0;
    slot     = 0;
    for (int k = N; k >= 1; k--) begin
      slot = (int'(last_owner_i) + k) % N;
      for (int j = 0; j < N; j++) begin
        if (j == slot && pending_i[j]) begin
          valid_o  = 1'b1;
          winner_o = 2'(j);
        end
      end
    end
  end

`else

  logic unused_last_owner;
  assign unused_last_owner = ^last_owner_i;

  // Scan downwards so the lowest pending index is the last assignment
  always_comb begin
    valid_o  = 1'b0;
    winner_o = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        valid_o  = 1'b1;
        winner_o = 2'(i);
      end
    end
  end

`endif

endmodule : dmgplus_rom_arb_pick

// File: rtl/dmgplus_rom_arbiter.sv
// Shares the cartridge ROM read port among NREQ requesters (0 = splash loader, 1 = CPU).
// Each requester keeps its rd-pulse / bsy / data handshake; reads are serialised onto the
// physical port and each byte is returned to its owner. Selection policy lives in
// dmgplus_rom_arb_pick and switches to round robin when ROM_ARB_RR_EN is defined.
module dmgplus_rom_arbiter
  import dmgplus_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk_8m,
  input  logic                 rst,
  input  logic [16*NREQ-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_rd,
  output logic [NREQ-1:0]      req_bsy,
  output logic [8*NREQ-1:0]    req_data,
  output logic [15:0]          rom_addr,
  output logic                 rom_rd,
  input  logic                 rom_bsy,
  input  logic [7:0]           rom_data,
  output logic [1:0]           owner,
  output logic                 active
);

  arb_state_e            state_q, state_d;
  logic [NREQ-1:0]       pending_q, pending_d;
  logic [NREQ-1:0][15:0] addr_q, addr_d;
  logic [NREQ-1:0][7:0]  data_q, data_d;
  logic [15:0]           rom_addr_q, rom_addr_d;
  logic                  rom_rd_q, rom_rd_d;
  logic [1:0]            owner_q, owner_d;
  logic [1:0]            last_owner_q, last_owner_d;
  logic                  active_q, active_d;
  logic                  wait_first_q, wait_first_d;

  logic                  pick_valid;
  logic [1:0]            pick_winner;

  dmgplus_rom_arb_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .pending_i    (pending_q),
    .last_owner_i (last_owner_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  // Next-state: request capture, then the serialising FSM
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rom_addr_d   = rom_addr_q;
    rom_rd_d     = 1'b0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    active_d     = active_q;
    wait_first_d = wait_first_q;

    // A read pulse while already pending is a protocol violation and is dropped
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_rd[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        addr_d[i]    = req_addr[16*i +: 16];
      end
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d      = pick_winner;
          last_owner_d = pick_winner;
          for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_winner == 2'(i)) rom_addr_d = addr_q[i];
          end
          rom_rd_d = 1'b1;
          active_d = 1'b1;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        wait_first_d = 1'b1;
        state_d      = ARB_WAIT;
      end
      ARB_WAIT: begin
        // rom_bsy may not have risen yet on the first WAIT cycle
        wait_first_d = 1'b0;
        if (!wait_first_q && !rom_bsy) begin
          for (int i = 0; i < int'(NREQ); i++) begin
            if (owner_q == 2'(i)) begin
              data_d[i]    = rom_data;
              pending_d[i] = 1'b0;
            end
          end
          active_d = 1'b0;
          state_d  = ARB_DONE;
        end
      end
      ARB_DONE: begin
        owner_d = 2'd0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // All state and registered outputs; reset abandons any read in flight
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      pending_q    <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rom_addr_q   <= 16'd0;
      rom_rd_q     <= 1'b0;
      owner_q      <= 2'd0;
      last_owner_q <= 2'(NREQ - 1);
      active_q     <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rom_addr_q   <= rom_addr_d;
      rom_rd_q     <= rom_rd_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      active_q     <= active_d;
      wait_first_q <= wait_first_d;
    end
  end

  assign req_bsy  = pending_q;
  assign req_data = data_q;
  assign rom_addr = rom_addr_q;
  assign rom_rd   = rom_rd_q;
  assign owner    = owner_q;
  assign active   = active_q;

endmodule : dmgplus_rom_arbiter

// File: tb/tb_dmgplus_rom_arbiter.sv
// Directed bench for dmgplus_rom_arbiter (NREQ=2) with a simple ROM model:
// bsy for 3 cycles after rd, data = addr[7:0] ^ 8'hA5.
module tb_dmgplus_rom_arbiter;
  import dmgplus_pkg::*;

  logic        clk_8m = 1'b0;
  logic        rst    = 1'b1;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_rd   = '0;
  logic [1:0]  req_bsy;
  logic [15:0] req_data;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic        rom_bsy;
  logic [7:0]  rom_data;
  logic [1:0]  owner;
  logic        active;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_8m = ~clk_8m;

  dmgplus_rom_arbiter #(
    .NREQ (2)
  ) dut (
    .clk_8m   (clk_8m),
    .rst      (rst),
    .req_addr (req_addr),
    .req_rd   (req_rd),
    .req_bsy  (req_bsy),
    .req_data (req_data),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd),
    .rom_bsy  (rom_bsy),
    .rom_data (rom_data),
    .owner    (owner),
    .active   (active)
  );

  // ROM model
  int          rom_cnt = 0;
  logic [15:0] rom_lat = '0;
  always @(posedge clk_8m) begin
    if (rom_rd === 1'b1) begin
      rom_cnt <= 3;
      rom_lat <= rom_addr;
    end else if (rom_cnt != 0) begin
      rom_cnt <= rom_cnt - 1;
    end
  end
  assign rom_bsy  = (rom_cnt != 0);
  assign rom_data = rom_lat[7:0] ^ 8'hA5;

  // Physical-port monitor
  logic [1:0]  own_log[$];
  logic [15:0] addr_log[$];
  logic        rd_prev  = 1'b0;
  int          wide_cnt = 0;
  always @(negedge clk_8m) begin
    if (rom_rd === 1'b1) begin
      own_log.push_back(owner);
      addr_log.push_back(rom_addr);
      if (rd_prev) wide_cnt <= wide_cnt + 1;
    end
    rd_prev <= (rom_rd === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_8m);
  endtask

  task automatic pulse_rd(input logic [1:0] m, input logic [15:0] a0, input logic [15:0] a1);
    req_addr = {a1, a0};
    req_rd   = m;
    @(negedge clk_8m);
    req_rd   = 2'b00;
  endtask

  task automatic wait_done(input int idx);
    int c;
    c = 0;
    while (req_bsy[idx] && c < 64) begin
      @(negedge clk_8m);
      c++;
    end
    if (req_bsy[idx]) check("timeout_bsy", 32'(req_bsy[idx]), 32'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_bsy"},  32'(req_bsy),  32'd0);
    check({pfx, "_req_data"}, 32'(req_data), 32'd0);
    check({pfx, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({pfx, "_rom_rd"},   32'(rom_rd),   32'd0);
    check({pfx, "_owner"},    32'(owner),    32'd0);
    check({pfx, "_active"},   32'(active),   32'd0);
  endtask

  initial begin
    int         base;
    int         issued;
    int         cnt0;
    logic [1:0] prev;
    logic [1:0] exp_own[8];
    int         exp_cnt0;

`ifdef ROM_ARB_RR_EN
    exp_own  = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    exp_cnt0 = 4;
`else
    exp_own  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    exp_cnt0 = 7;
`endif

    tick(3);
    rst = 1'b0;
    check_reset_vals("reset");

    // 1 Single read
    base = own_log.size();
    pulse_rd(2'b01, 16'h0100, 16'h0000);
    check("t1_bsy0_high", 32'(req_bsy[0]), 32'd1);
    check("t1_bsy1_low",  32'(req_bsy[1]), 32'd0);
    wait_done(0);
    tick(2);
    check("t1_data0",   32'(req_data[7:0]), 32'h0000_00A5);
    check("t1_rd_cnt",  32'(own_log.size() - base), 32'd1);
    check("t1_rom_addr", 32'(addr_log[base]), 32'h0000_0100);
    check("t1_bsy1_still_low", 32'(req_bsy[1]), 32'd0);
    check("t1_active_idle", 32'(active), 32'd0);

    // 2 Simultaneous requests from a fresh reset
    reset_dut();
    base = own_log.size();
    pulse_rd(2'b11, 16'h0134, 16'h0200);
    check("t2_bsy_both", 32'(req_bsy), 32'd3);
    wait_done(0);
    wait_done(1);
    tick(2);
    check("t2_data0",  32'(req_data[7:0]),  32'h0000_0091);
    check("t2_data1",  32'(req_data[15:8]), 32'h0000_00A5);
    check("t2_rd_cnt", 32'(own_log.size() - base), 32'd2);
    check("t2_first_owner",  32'(own_log[base]),     32'd0);
    check("t2_second_owner", 32'(own_log[base + 1]), 32'd1);

    // 3 Both requesters re-request right after each completion
    base   = own_log.size();
    issued = 2;
    prev   = 2'b00;
    pulse_rd(2'b11, 16'h0400, 16'h0500);
    for (int c = 0; c < 300; c++) begin
      req_rd = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (prev[i] && !req_bsy[i] && issued < 8) begin
          req_rd[i] = 1'b1;
          req_addr[16*i +: 16] = 16'h0400 + 16'(issued);
          issued++;
        end
      end
      prev = req_bsy;
      if (issued >= 8 && req_bsy == 2'b00 && req_rd == 2'b00) break;
      @(negedge clk_8m);
    end
    req_rd = 2'b00;
    tick(2);
    check("t3_rd_cnt", 32'(own_log.size() - base), 32'd8);
    cnt0 = 0;
    for (int k = 0; k < 8; k++) begin
      if (base + k < own_log.size()) begin
        check($sformatf("t3_owner_%0d", k), 32'(own_log[base + k]), 32'(exp_own[k]));
        if (own_log[base + k] == 2'd0) cnt0++;
      end
    end
    check("t3_reads_req0", 32'(cnt0), 32'(exp_cnt0));

    // 4 Protocol violation: second pulse while busy is dropped
    base = own_log.size();
    pulse_rd(2'b10, 16'h0000, 16'h0280);
    check("t4_bsy1_high", 32'(req_bsy[1]), 32'd1);
    pulse_rd(2'b10, 16'h0000, 16'h0300);
    wait_done(1);
    tick(12);
    check("t4_rd_cnt",   32'(own_log.size() - base), 32'd1);
    check("t4_rom_addr", 32'(addr_log[base]), 32'h0000_0280);
    check("t4_data1",    32'(req_data[15:8]), 32'h0000_0025);
    check("t4_bsy1_low", 32'(req_bsy[1]), 32'd0);

    // 5 Reset during WAIT
    base = own_log.size();
    pulse_rd(2'b01, 16'h0142, 16'h0000);
    for (int c = 0; c < 20 && rom_rd !== 1'b1; c++) @(negedge clk_8m);
    check("t5_issue_seen", 32'(rom_rd), 32'd1);
    @(negedge clk_8m);
    check("t5_in_wait_active", 32'(active), 32'd1);
    rst = 1'b1;
    @(negedge clk_8m);
    rst = 1'b0;
    check_reset_vals("t5_after_rst");
    tick(8);
    check("t5_no_reissue", 32'(own_log.size() - base), 32'd1);
    check("t5_data_untouched", 32'(req_data), 32'd0);
    pulse_rd(2'b10, 16'h0000, 16'h0155);
    wait_done(1);
    tick(1);
    check("t5_new_data1", 32'(req_data[15:8]), 32'h0000_00F0);
    check("t5_new_data0", 32'(req_data[7:0]),  32'd0);

    // 6 Hold: req 0 data stays while req 1 reads repeatedly
    pulse_rd(2'b01, 16'h0100, 16'h0000);
    wait_done(0);
    tick(1);
    check("t6_data0_init", 32'(req_data[7:0]), 32'h0000_00A5);
    for (int k = 0; k < 3; k++) begin
      pulse_rd(2'b10, 16'h0000, 16'h0211 + 16'(k * 16'h11));
      wait_done(1);
      tick(1);
      check($sformatf("t6_data1_%0d", k), 32'(req_data[15:8]),
            32'((8'h11 + 8'(k * 8'h11)) ^ 8'hA5));
      check($sformatf("t6_data0_hold_%0d", k), 32'(req_data[7:0]), 32'h0000_00A5);
    end

    check("rom_rd_single_cycle", 32'(wide_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dmgplus_rom_arbiter
